// File: rtl/b13_serial_rx_pkg.sv
// Shared types and frame constants for the b13 serial receiver.
package b13_rx_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DATA = 2'd1,
        R_STOP = 2'd2
    } rx_state_t;

    localparam int   FRAME_DATA_BITS    = 8;
    localparam logic START_LEVEL        = 1'b0;
    localparam logic STOP_LEVEL         = 1'b1;
    localparam int   DEFAULT_DELAY_TIME = 104;

endpackage

// File: rtl/b13_serial_rx_if.sv
// Serial line plus byte handshake of the b13 receiver; B13_RX_OVERRUN_EN adds rx_overrun.
interface b13_serial_rx_if;

    logic       serial_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_error;
    logic       rx_busy;
`ifdef B13_RX_OVERRUN_EN
    logic       rx_overrun;
`endif

`ifdef B13_RX_OVERRUN_EN
    modport slave (
        input  serial_in, rx_ack,
        output rx_data, rx_valid, frame_error, rx_busy, rx_overrun
    );
    modport master (
        output serial_in, rx_ack,
        input  rx_data, rx_valid, frame_error, rx_busy, rx_overrun
    );
`else
    modport slave (
        input  serial_in, rx_ack,
        output rx_data, rx_valid, frame_error, rx_busy
    );
    modport master (
        output serial_in, rx_ack,
        input  rx_data, rx_valid, frame_error, rx_busy
    );
`endif

endinterface

// File: rtl/b13_serial_rx_bit_timer.sv
// Bit-period counter: while enabled, pulses strobe on every BIT_PERIOD-th cycle.
module b13_rx_bit_timer #(
    parameter int BIT_PERIOD = 106,
    parameter int CNT_W      = 10
) (
    input  logic clock,
    input  logic rst_n,
    input  logic en,
    output logic strobe
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_PERIOD - 1);

    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;

    // Held at zero while disabled so the first strobe lands one full period after enable.
    always_comb begin
        strobe       = en && (period_cnt_q == LAST);
        period_cnt_d = period_cnt_q;
        if (!en || strobe) begin
            period_cnt_d = '0;
        end else begin
            period_cnt_d = period_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

endmodule

// File: rtl/b13_serial_rx.sv
// Pulse-style serial receiver (start, 8 data bits MSB first, stop) with valid/ack output.
// Optional B13_RX_OVERRUN_EN adds a sticky overrun flag for unacknowledged overwrites.
module b13_serial_rx
    import b13_rx_pkg::*;
#(
    parameter int DELAY_TIME = DEFAULT_DELAY_TIME,
    parameter int CNT_W      = 10
) (
    input  logic          clock,
    input  logic          rst_n,
    b13_serial_rx_if.slave rx,
    output rx_state_t     dbg_state
);

    localparam int BIT_PERIOD = DELAY_TIME + 2;

    rx_state_t  state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_error_q, frame_error_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       strobe;
    logic       handshake;
    logic       good_byte;

    b13_rx_bit_timer #(
        .BIT_PERIOD(BIT_PERIOD),
        .CNT_W     (CNT_W)
    ) u_bit_timer (
        .clock (clock),
        .rst_n (rst_n),
        .en    (state_q != R_IDLE),
        .strobe(strobe)
    );

    // Handshake: rx_valid is a level held until a posedge sees rx_valid && rx_ack;
    // a good stop in that same cycle republishes, so the new byte wins.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_error_d = frame_error_q;
        rx_overrun_d  = rx_overrun_q;
        good_byte     = 1'b0;
        handshake     = rx_valid_q && rx.rx_ack;

        if (handshake) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
        end

        case (state_q)
            R_IDLE: begin
                bit_cnt_d = '0;
                if (rx.serial_in == START_LEVEL) begin
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (strobe) begin
                    shift_d   = {shift_q[6:0], rx.serial_in};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(FRAME_DATA_BITS - 1)) begin
                        state_d = R_STOP;
                    end
                end
            end
            R_STOP: begin
                if (strobe) begin
                    state_d   = R_IDLE;
                    bit_cnt_d = '0;
                    if (rx.serial_in == STOP_LEVEL) begin
                        good_byte = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = R_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        if (good_byte) begin
            rx_data_d     = shift_q;
            rx_valid_d    = 1'b1;
            frame_error_d = 1'b0;
            if (rx_valid_q && !rx.rx_ack) begin
                rx_overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q       <= R_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

    assign rx.rx_data     = rx_data_q;
    assign rx.rx_valid    = rx_valid_q;
    assign rx.frame_error = frame_error_q;
    assign rx.rx_busy     = (state_q != R_IDLE);
    assign dbg_state      = state_q;

`ifdef B13_RX_OVERRUN_EN
    assign rx.rx_overrun = rx_overrun_q;
`else
    logic unused_overrun;
    assign unused_overrun = rx_overrun_q;
`endif

endmodule

// File: tb/tb_b13_serial_rx.sv
// Bench for b13_serial_rx: directed frames plus randomized traffic against a cycle-timed reference.
module tb_b13_serial_rx;
  import b13_rx_pkg::*;

  localparam int BP = DEFAULT_DELAY_TIME + 2;

  // clock / reset
  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  b13_serial_rx_if rx_if ();
  rx_state_t dbg_state;

  b13_serial_rx #(
    .DELAY_TIME(DEFAULT_DELAY_TIME),
    .CNT_W     (10)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .rx       (rx_if),
    .dbg_state(dbg_state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // reference model state
  bit         m_valid = 0;
  bit         m_ferr  = 0;
  bit         m_ovr   = 0;
  bit         m_busy  = 0;
  logic [7:0] m_data  = 8'h00;
  int         m_start = 0;
  int         cyc     = 0;

  // consumer control: 0 never acks, 1 acks within 0..4 cycles, 2 random acks
  int ack_mode  = 0;
  bit ack_force = 0;
  int ack_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference at the edge, then check outputs.
  task automatic cycle(input logic ser, input logic rst);
    logic ack;
    int   pos;
    bit   pub, bad, hs;
    rx_state_t exp_st;
    ack = 1'b0;
    if (ack_force) ack = 1'b1;
    else if (ack_mode == 1) begin
      if (m_valid) begin
        if (ack_cnt == 0) ack = 1'b1;
        else ack_cnt--;
      end else begin
        ack = ($urandom_range(0, 7) == 0);
      end
    end else if (ack_mode == 2) begin
      ack = ($urandom_range(0, 3) == 0);
    end
    rx_if.serial_in = ser;
    rx_if.rx_ack    = ack;
    rst_n           = ~rst;
    @(posedge clock);
    cyc++;
    pub = 0;
    bad = 0;
    if (rst) begin
      m_valid = 0; m_ferr = 0; m_ovr = 0; m_busy = 0; m_data = 8'h00;
    end else begin
      if (m_busy) begin
        pos = cyc - m_start;
        if (pos == 9 * BP) begin
          m_busy = 0;
          if (ser) pub = 1;
          else bad = 1;
        end
      end else if (ser == 1'b0) begin
        m_busy  = 1;
        m_start = cyc;
      end
      hs = m_valid && ack;
      if (hs) m_ovr = 0;
      if (pub && m_valid && !ack) m_ovr = 1;
      if (hs) m_valid = 0;
      if (pub) begin
        chk("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        m_valid = 1;
        m_ferr  = 0;
        if (exp_q.size() != 0) m_data = exp_q.pop_front();
      end
      if (bad) m_ferr = 1;
      if (hs || pub) ack_cnt = $urandom_range(0, 4);
    end
    #1;
    if (!m_busy) exp_st = R_IDLE;
    else if (cyc - m_start >= 8 * BP) exp_st = R_STOP;
    else exp_st = R_DATA;
    chk("rx_valid", 32'(rx_if.rx_valid), 32'(m_valid));
    chk("rx_data", 32'(rx_if.rx_data), 32'(m_data));
    chk("frame_error", 32'(rx_if.frame_error), 32'(m_ferr));
    chk("rx_busy", 32'(rx_if.rx_busy), 32'(m_busy));
    chk("state", 32'(dbg_state), 32'(exp_st));
`ifdef B13_RX_OVERRUN_EN
    chk("rx_overrun", 32'(rx_if.rx_overrun), 32'(m_ovr));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
  endtask

  task automatic ack_once();
    ack_force = 1;
    cycle(1'b1, 1'b0);
    ack_force = 0;
  endtask

  // Driver: one pulse-style frame, optional reset at offset rst_at, optional ack on stop sample.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_at,
                            input bit collide, input bit noise, input int gap);
    logic s;
    if (stop_bit && rst_at < 0) exp_q.push_back(b);
    for (int k = 0; k <= 9 * BP; k++) begin
      if (k == rst_at) begin
        cycle(1'b1, 1'b1);
        break;
      end
      s = 1'b1;
      if (k == 0) s = 1'b0;
      else if (k % BP == 0 && k < 9 * BP) s = b[8 - k / BP];
      else if (k == 9 * BP) s = stop_bit;
      else if (noise) s = 1'($urandom_range(0, 1));
      ack_force = collide && (k == 9 * BP);
      cycle(s, 1'b0);
      ack_force = 0;
    end
    idle(gap);
  endtask

  initial begin
    rx_if.serial_in = 1'b1;
    rx_if.rx_ack    = 1'b0;
    rst_n           = 1'b0;
    repeat (3) cycle(1'b1, 1'b1);
    idle(6);

    // good frame then a single ack
    send_frame(8'hA5, 1'b1, -1, 0, 0, 5);
    ack_once();
    idle(100);

    // framing error, then recovery
    ack_mode = 1;
    send_frame(8'h3C, 1'b0, -1, 0, 0, BP - 1);
    send_frame(8'h01, 1'b1, -1, 0, 0, BP - 1);

    // back-to-back at the earliest next start
    send_frame(8'hFF, 1'b1, -1, 0, 0, BP - 1);
    send_frame(8'h00, 1'b1, -1, 0, 0, BP - 1);

    // ack collides with the next good stop
    ack_mode = 0;
    send_frame(8'h11, 1'b1, -1, 0, 0, BP - 1);
    send_frame(8'h22, 1'b1, -1, 1, 0, 5);
    ack_once();
    idle(20);

    // reset mid-frame, then a fresh frame
    send_frame(8'hC3, 1'b1, 400, 0, 0, 20);
    ack_mode = 1;
    send_frame(8'h5A, 1'b1, -1, 0, 0, BP - 1);

    // overrun: two good frames without ack
    ack_mode = 0;
    send_frame(8'h12, 1'b1, -1, 0, 0, BP - 1);
    send_frame(8'h34, 1'b1, -1, 0, 0, 5);
    ack_once();
    idle(10);

    // randomized traffic with noise between sample points
    for (int f = 0; f < 20; f++) begin
      ack_mode = $urandom_range(0, 2);
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 5) != 0), -1, 0, 1,
                 $urandom_range(BP - 1, BP + 35));
    end
    ack_mode = 1;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
